// File: rtl/csr_irq_timer_if.sv
// -----------------------------------------------------------------------------
// csr_irq_timer_if
// CSR access channel between the idex stage (master) and csr_irq_timer (slave).
//   csr_we_i    : write strobe, the write lands at the next clock edge
//   csr_addr_i  : 12-bit CSR address
//   csr_wdata_i : 32-bit write data
//   csr_rdata_o : 32-bit read data, combinational from csr_addr_i
// -----------------------------------------------------------------------------
interface csr_irq_timer_if;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;

  modport master (
    output csr_we_i,
    output csr_addr_i,
    output csr_wdata_i,
    input  csr_rdata_o
  );

  modport slave (
    input  csr_we_i,
    input  csr_addr_i,
    input  csr_wdata_i,
    output csr_rdata_o
  );
endinterface

// File: rtl/csr_irq_timer.sv
// -----------------------------------------------------------------------------
// csr_irq_timer
// Machine timer (mtime/mtimecmp with prescaler), machine software interrupt
// and NUM_EXT_IRQ external interrupt lines with per-line enable, level/edge
// mode and a lowest-index-wins claim/complete scheme.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   csr           : CSR channel (slave modport of csr_irq_timer_if)
//   irq_i         : raw external interrupt lines
//   hx_valid      : writeback-valid; request outputs only update when high
//   mie_i         : {MEIE, MTIE, MSIE}
//   ext_irq_o     : masked external request
//   ext_irq_id_o  : winning line index+1, 0 when none
//   tmr_irq_o     : masked timer request
//   sw_irq_o      : masked software request
//
// Build option: define IRQ_SYNC_EN to pass irq_i through a 2-flop
// synchroniser before the level/edge logic (adds 2 cycles of latency).
// -----------------------------------------------------------------------------
module csr_irq_timer #(
  parameter int NUM_EXT_IRQ = 8,
  parameter int TIMER_W     = 64,
  parameter int PRESCALE_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  csr_irq_timer_if.slave         csr,
  input  logic [NUM_EXT_IRQ-1:0] irq_i,
  input  logic                   hx_valid,
  input  logic [2:0]             mie_i,
  output logic                   ext_irq_o,
  output logic [4:0]             ext_irq_id_o,
  output logic                   tmr_irq_o,
  output logic                   sw_irq_o
);

  localparam int N    = NUM_EXT_IRQ;
  localparam int HI_W = TIMER_W - 32;

  localparam logic [11:0] A_TCTRL     = 12'hBC0;
  localparam logic [11:0] A_MTIME     = 12'hBC1;
  localparam logic [11:0] A_MTIMEH    = 12'hBC2;
  localparam logic [11:0] A_MTIMECMP  = 12'hBC3;
  localparam logic [11:0] A_MTIMECMPH = 12'hBC4;
  localparam logic [11:0] A_XIE       = 12'hBC5;
  localparam logic [11:0] A_XIP       = 12'hBC6;
  localparam logic [11:0] A_XMODE     = 12'hBC7;
  localparam logic [11:0] A_XCLAIM    = 12'hBC8;
  localparam logic [11:0] A_MSIP      = 12'hBC9;

  localparam logic [TIMER_W-1:0]    T_ONE = 1;
  localparam logic [PRESCALE_W-1:0] P_ONE = 1;

  // State
  logic                  tctrl_en_q, tctrl_en_d;
  logic [PRESCALE_W-1:0] tctrl_div_q, tctrl_div_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [TIMER_W-1:0]    mtime_q, mtime_d;
  logic [TIMER_W-1:0]    mtimecmp_q, mtimecmp_d;
  logic [N-1:0]          xie_q, xie_d;
  logic [N-1:0]          xmode_q, xmode_d;
  logic [N-1:0]          edge_pend_q, edge_pend_d;
  logic [N-1:0]          irq_prev_q;
  logic                  msip_q, msip_d;
  logic                  ext_irq_q, tmr_irq_q, sw_irq_q;
  logic [4:0]            ext_id_q;

  // Combinational helpers
  logic [N-1:0] irq_s;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] pend;
  logic [N-1:0] active;
  logic [4:0]   claim_id;
  logic         tick;
  logic         tmr_pend;
  logic [31:0]  wdata;
  logic         wr_tctrl, wr_mtime, wr_mtimeh, wr_cmp, wr_cmph;
  logic         wr_xie, wr_xip, wr_xmode, wr_xclaim, wr_msip;

  assign wdata     = csr.csr_wdata_i;
  assign wr_tctrl  = csr.csr_we_i && (csr.csr_addr_i == A_TCTRL);
  assign wr_mtime  = csr.csr_we_i && (csr.csr_addr_i == A_MTIME);
  assign wr_mtimeh = csr.csr_we_i && (csr.csr_addr_i == A_MTIMEH);
  assign wr_cmp    = csr.csr_we_i && (csr.csr_addr_i == A_MTIMECMP);
  assign wr_cmph   = csr.csr_we_i && (csr.csr_addr_i == A_MTIMECMPH);
  assign wr_xie    = csr.csr_we_i && (csr.csr_addr_i == A_XIE);
  assign wr_xip    = csr.csr_we_i && (csr.csr_addr_i == A_XIP);
  assign wr_xmode  = csr.csr_we_i && (csr.csr_addr_i == A_XMODE);
  assign wr_xclaim = csr.csr_we_i && (csr.csr_addr_i == A_XCLAIM);
  assign wr_msip   = csr.csr_we_i && (csr.csr_addr_i == A_MSIP);

`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_i;
`endif

  // Timer and prescaler next state
  always_comb begin
    tick        = tctrl_en_q && (presc_q == tctrl_div_q);
    tctrl_en_d  = tctrl_en_q;
    tctrl_div_d = tctrl_div_q;
    presc_d     = presc_q;
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;

    if (tctrl_en_q) presc_d = tick ? '0 : presc_q + P_ONE;
    if (wr_tctrl) begin
      tctrl_en_d  = wdata[0];
      tctrl_div_d = wdata[8 +: PRESCALE_W];
      presc_d     = '0;
    end

    // A software write to either half drops that cycle's tick entirely.
    if (wr_mtime)       mtime_d[31:0]         = wdata;
    else if (wr_mtimeh) mtime_d[TIMER_W-1:32] = wdata[HI_W-1:0];
    else if (tick)      mtime_d               = mtime_q + T_ONE;

    if (wr_cmp)  mtimecmp_d[31:0]         = wdata;
    if (wr_cmph) mtimecmp_d[TIMER_W-1:32] = wdata[HI_W-1:0];
  end

  assign tmr_pend = (mtime_q >= mtimecmp_q);

  // External line next state and claim arbitration
  always_comb begin
    xie_d   = wr_xie   ? wdata[N-1:0] : xie_q;
    xmode_d = wr_xmode ? wdata[N-1:0] : xmode_q;
    msip_d  = wr_msip  ? wdata[0]     : msip_q;
    rise    = irq_s & ~irq_prev_q;

    clr = '0;
    if (wr_xip) clr = wdata[N-1:0];
    for (int k = 0; k < N; k++) begin
      if (wr_xclaim && (wdata == 32'(k + 1))) clr[k] = 1'b1;
    end

    // Set beats clear; masking with the next mode drops pending state on
    // lines leaving edge mode and keeps level lines' edge bits at zero.
    edge_pend_d = ((edge_pend_q & ~clr) | rise) & xmode_d;

    pend   = (xmode_q & edge_pend_q) | (~xmode_q & irq_s);
    active = pend & xie_q;

    claim_id = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (active[k]) claim_id = 5'(k + 1);
    end
  end

  // CSR read mux
  always_comb begin
    csr.csr_rdata_o = '0;
    unique case (csr.csr_addr_i)
      A_TCTRL: begin
        csr.csr_rdata_o[0]               = tctrl_en_q;
        csr.csr_rdata_o[8 +: PRESCALE_W] = tctrl_div_q;
      end
      A_MTIME:     csr.csr_rdata_o            = mtime_q[31:0];
      A_MTIMEH:    csr.csr_rdata_o[HI_W-1:0]  = mtime_q[TIMER_W-1:32];
      A_MTIMECMP:  csr.csr_rdata_o            = mtimecmp_q[31:0];
      A_MTIMECMPH: csr.csr_rdata_o[HI_W-1:0]  = mtimecmp_q[TIMER_W-1:32];
      A_XIE:       csr.csr_rdata_o[N-1:0]     = xie_q;
      A_XIP:       csr.csr_rdata_o[N-1:0]     = pend;
      A_XMODE:     csr.csr_rdata_o[N-1:0]     = xmode_q;
      A_XCLAIM:    csr.csr_rdata_o[4:0]       = claim_id;
      A_MSIP:      csr.csr_rdata_o[0]         = msip_q;
      default:     csr.csr_rdata_o            = '0;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tctrl_en_q  <= 1'b0;
      tctrl_div_q <= '0;
      presc_q     <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      xie_q       <= '0;
      xmode_q     <= '0;
      edge_pend_q <= '0;
      irq_prev_q  <= '0;
      msip_q      <= 1'b0;
    end else begin
      tctrl_en_q  <= tctrl_en_d;
      tctrl_div_q <= tctrl_div_d;
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      xie_q       <= xie_d;
      xmode_q     <= xmode_d;
      edge_pend_q <= edge_pend_d;
      irq_prev_q  <= irq_s;
      msip_q      <= msip_d;
    end
  end

  // Request outputs, sampled only on writeback-valid cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_irq_q <= 1'b0;
      ext_id_q  <= '0;
      tmr_irq_q <= 1'b0;
      sw_irq_q  <= 1'b0;
    end else if (hx_valid) begin
      ext_irq_q <= mie_i[2] && (claim_id != 5'd0);
      ext_id_q  <= claim_id;
      tmr_irq_q <= mie_i[1] && tmr_pend;
      sw_irq_q  <= mie_i[0] && msip_q;
    end
  end

  assign ext_irq_o    = ext_irq_q;
  assign ext_irq_id_o = ext_id_q;
  assign tmr_irq_o    = tmr_irq_q;
  assign sw_irq_o     = sw_irq_q;

endmodule

// File: tb/tb_csr_irq_timer.sv
// -----------------------------------------------------------------------------
// tb_csr_irq_timer
// Directed bench for csr_irq_timer with hand-computed expected values.
// Inputs change on the falling edge; outputs and CSR reads are sampled just
// after the falling edge, away from the rising (active) edge.
// -----------------------------------------------------------------------------
module tb_csr_irq_timer;

  localparam int N = 8;

`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam logic [11:0] A_TCTRL     = 12'hBC0;
  localparam logic [11:0] A_MTIME     = 12'hBC1;
  localparam logic [11:0] A_MTIMEH    = 12'hBC2;
  localparam logic [11:0] A_MTIMECMP  = 12'hBC3;
  localparam logic [11:0] A_MTIMECMPH = 12'hBC4;
  localparam logic [11:0] A_XIE       = 12'hBC5;
  localparam logic [11:0] A_XIP       = 12'hBC6;
  localparam logic [11:0] A_XMODE     = 12'hBC7;
  localparam logic [11:0] A_XCLAIM    = 12'hBC8;
  localparam logic [11:0] A_MSIP      = 12'hBC9;

  logic         clk;
  logic         rst;
  logic [N-1:0] irq_i;
  logic         hx_valid;
  logic [2:0]   mie_i;
  logic         ext_irq_o;
  logic [4:0]   ext_irq_id_o;
  logic         tmr_irq_o;
  logic         sw_irq_o;

  int n_checks;
  int n_fail;

  csr_irq_timer_if bus ();

  csr_irq_timer #(
    .NUM_EXT_IRQ (N),
    .TIMER_W     (64),
    .PRESCALE_W  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csr          (bus.slave),
    .irq_i        (irq_i),
    .hx_valid     (hx_valid),
    .mie_i        (mie_i),
    .ext_irq_o    (ext_irq_o),
    .ext_irq_id_o (ext_irq_id_o),
    .tmr_irq_o    (tmr_irq_o),
    .sw_irq_o     (sw_irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one write; returns at the falling edge after the write has landed.
  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we_i    = 1'b1;
    bus.csr_addr_i  = a;
    bus.csr_wdata_i = d;
    @(negedge clk);
    bus.csr_we_i    = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    bus.csr_addr_i = a;
    #1;
    d = bus.csr_rdata_o;
  endtask

  logic [31:0] rd;
  logic [31:0] frozen;

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    irq_i           = '0;
    hx_valid        = 1'b0;
    mie_i           = 3'b000;
    bus.csr_we_i    = 1'b0;
    bus.csr_addr_i  = '0;
    bus.csr_wdata_i = '0;
    cycles(3);
    rst = 1'b0;

    // Reset state
    check_eq("rst_ext", {63'd0, ext_irq_o}, 64'd0);
    check_eq("rst_id",  {59'd0, ext_irq_id_o}, 64'd0);
    check_eq("rst_tmr", {63'd0, tmr_irq_o}, 64'd0);
    check_eq("rst_sw",  {63'd0, sw_irq_o}, 64'd0);
    csr_rd(A_MTIME, rd);     check_eq("rst_mtime", {32'd0, rd}, 64'd0);
    csr_rd(A_MTIMECMP, rd);  check_eq("rst_cmp_lo", {32'd0, rd}, 64'hFFFF_FFFF);
    csr_rd(A_MTIMECMPH, rd); check_eq("rst_cmp_hi", {32'd0, rd}, 64'hFFFF_FFFF);
    csr_rd(A_TCTRL, rd);     check_eq("rst_tctrl", {32'd0, rd}, 64'd0);
    csr_rd(12'h123, rd);     check_eq("unmapped", {32'd0, rd}, 64'd0);

    // Timer tick with DIV=3: one increment every 4 cycles
    csr_wr(A_MTIME, 32'd0);
    csr_wr(A_TCTRL, 32'h0000_0301);
    csr_rd(A_TCTRL, rd);     check_eq("tctrl_rd", {32'd0, rd}, 64'h301);
    cycles(4);
    csr_rd(A_MTIME, rd);     check_eq("tick_4", {32'd0, rd}, 64'd1);
    cycles(16);
    csr_rd(A_MTIME, rd);     check_eq("tick_20", {32'd0, rd}, 64'd5);
    csr_wr(A_TCTRL, 32'd0);
    csr_rd(A_MTIME, frozen);
    cycles(10);
    csr_rd(A_MTIME, rd);     check_eq("tick_frozen", {32'd0, rd}, {32'd0, frozen});
    check_eq("frozen_val", {32'd0, frozen}, 64'd5);

    // Timer compare and wrap
    csr_wr(A_MTIMEH, 32'hFFFF_FFFF);
    csr_wr(A_MTIME,  32'hFFFF_FFFE);
    mie_i    = 3'b010;
    hx_valid = 1'b1;
    cycles(1);
    check_eq("tmr_below", {63'd0, tmr_irq_o}, 64'd0);
    csr_wr(A_TCTRL, 32'h0000_0001);
    cycles(1);
    csr_rd(A_MTIME, rd);     check_eq("mtime_at_cmp", {32'd0, rd}, 64'hFFFF_FFFF);
    check_eq("tmr_not_yet", {63'd0, tmr_irq_o}, 64'd0);
    cycles(1);
    csr_rd(A_MTIME, rd);     check_eq("wrap_lo", {32'd0, rd}, 64'd0);
    csr_rd(A_MTIMEH, rd);    check_eq("wrap_hi", {32'd0, rd}, 64'd0);
    check_eq("tmr_rise", {63'd0, tmr_irq_o}, 64'd1);
    cycles(1);
    check_eq("tmr_fall", {63'd0, tmr_irq_o}, 64'd0);
    csr_wr(A_TCTRL, 32'd0);

    // Edge lines: priority and claim/complete
    mie_i = 3'b100;
    csr_wr(A_XMODE, 32'hFF);
    csr_wr(A_XIE,   32'h0C);
    irq_i = 8'h08; cycles(1); irq_i = 8'h00; cycles(1);
    irq_i = 8'h04; cycles(1); irq_i = 8'h00; cycles(1 + SYNC_LAT);
    csr_rd(A_XIP, rd);       check_eq("xip_edges", {32'd0, rd}, 64'h0C);
    csr_rd(A_XCLAIM, rd);    check_eq("claim_first", {32'd0, rd}, 64'd3);
    cycles(1);
    check_eq("ext_on", {63'd0, ext_irq_o}, 64'd1);
    check_eq("ext_id3", {59'd0, ext_irq_id_o}, 64'd3);
    csr_wr(A_XCLAIM, 32'd3);
    csr_rd(A_XCLAIM, rd);    check_eq("claim_second", {32'd0, rd}, 64'd4);
    cycles(1);
    check_eq("ext_id4", {59'd0, ext_irq_id_o}, 64'd4);
    csr_wr(A_XCLAIM, 32'd4);
    csr_rd(A_XCLAIM, rd);    check_eq("claim_none", {32'd0, rd}, 64'd0);
    cycles(1);
    check_eq("ext_off", {63'd0, ext_irq_o}, 64'd0);
    check_eq("ext_id0", {59'd0, ext_irq_id_o}, 64'd0);

    // Leaving edge mode drops the pending bit
    irq_i = 8'h20; cycles(1); irq_i = 8'h00; cycles(1 + SYNC_LAT);
    csr_rd(A_XIP, rd);       check_eq("xip_line5", {32'd0, rd}, 64'h20);
    csr_wr(A_XMODE, 32'hDF);
    csr_wr(A_XMODE, 32'hFF);
    csr_rd(A_XIP, rd);       check_eq("mode_clr", {32'd0, rd}, 64'h00);

    // Level line
    csr_wr(A_XMODE, 32'h00);
    csr_wr(A_XIE,   32'h01);
    irq_i = 8'h01;
    cycles(2 + SYNC_LAT);
    check_eq("lvl_ext", {63'd0, ext_irq_o}, 64'd1);
    check_eq("lvl_id",  {59'd0, ext_irq_id_o}, 64'd1);
    csr_wr(A_XIP, 32'h01);
    csr_rd(A_XIP, rd);       check_eq("lvl_w1c_ignored", {32'd0, rd}, 64'h01);
    cycles(1);
    check_eq("lvl_still_on", {63'd0, ext_irq_o}, 64'd1);
    irq_i = 8'h00;
    cycles(2 + SYNC_LAT);
    check_eq("lvl_off", {63'd0, ext_irq_o}, 64'd0);

    // Simultaneous edge set and W1C: set wins
    csr_wr(A_XMODE, 32'hFF);
    csr_wr(A_XIE,   32'h00);
    irq_i = 8'h02;
    cycles(SYNC_LAT);
    csr_wr(A_XIP, 32'h02);
    irq_i = 8'h00;
    csr_rd(A_XIP, rd);       check_eq("set_wins", {32'd0, rd}, 64'h02);
    csr_wr(A_XIP, 32'h02);
    csr_rd(A_XIP, rd);       check_eq("w1c_clear", {32'd0, rd}, 64'h00);

    // MTIME write on a tick cycle: write wins
    csr_wr(A_MTIME, 32'd0);
    csr_wr(A_TCTRL, 32'h0000_0001);
    cycles(2);
    csr_wr(A_MTIME, 32'h10);
    csr_rd(A_MTIME, rd);     check_eq("mtime_wr_wins", {32'd0, rd}, 64'h10);
    cycles(1);
    csr_rd(A_MTIME, rd);     check_eq("mtime_after_wr", {32'd0, rd}, 64'h11);

    // hx_valid gating of the software request
    hx_valid = 1'b0;
    mie_i    = 3'b001;
    csr_wr(A_MSIP, 32'd1);
    cycles(2);
    check_eq("sw_gated", {63'd0, sw_irq_o}, 64'd0);
    hx_valid = 1'b1;
    cycles(1);
    check_eq("sw_on", {63'd0, sw_irq_o}, 64'd1);
    cycles(3);
    csr_rd(A_MSIP, rd);      check_eq("msip_held", {32'd0, rd}, 64'd1);

    // Reset mid-count, overriding a CSR write in the same cycle
    mie_i = 3'b111;
    cycles(3);
    rst             = 1'b1;
    bus.csr_we_i    = 1'b1;
    bus.csr_addr_i  = A_MTIMECMP;
    bus.csr_wdata_i = 32'h1234;
    cycles(1);
    rst          = 1'b0;
    bus.csr_we_i = 1'b0;
    csr_rd(A_MTIME, rd);     check_eq("rst2_mtime", {32'd0, rd}, 64'd0);
    csr_rd(A_MTIMECMP, rd);  check_eq("rst2_cmp", {32'd0, rd}, 64'hFFFF_FFFF);
    csr_rd(A_TCTRL, rd);     check_eq("rst2_tctrl", {32'd0, rd}, 64'd0);
    csr_rd(A_MSIP, rd);      check_eq("rst2_msip", {32'd0, rd}, 64'd0);
    check_eq("rst2_sw",  {63'd0, sw_irq_o}, 64'd0);
    check_eq("rst2_tmr", {63'd0, tmr_irq_o}, 64'd0);
    check_eq("rst2_ext", {63'd0, ext_irq_o}, 64'd0);
    cycles(3);
    csr_rd(A_MTIME, rd);     check_eq("rst2_frozen", {32'd0, rd}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
